// File: rtl/encoder42_hs.sv
// Sequential 4-to-2 priority encoder with input debounce and a valid/ready result port.
// A request pattern must be stable for STABLE_CYCLES samples before it is captured; after
// the result is accepted, all lines must return low before the next capture can start.
module encoder42_hs #(
    parameter int unsigned STABLE_CYCLES = 3,
    parameter int unsigned CNT_W         = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic y0,
    input  logic y1,
    input  logic y2,
    input  logic y3,
    input  logic ready,
    output logic a,
    output logic b,
    output logic valid,
    output logic multi,
    output logic busy
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StStable  = 2'd1;
    localparam logic [1:0] StValid   = 2'd2;
    localparam logic [1:0] StRelease = 2'd3;

    localparam logic [CNT_W-1:0] StableCnt = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

    logic [3:0]       req;
    logic [1:0]       state_q, state_d;
    logic [3:0]       snap_q, snap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             multi_q, multi_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             load;
    logic [3:0]       load_pat;
    logic [CNT_W-1:0] cnt_inc;

    assign req     = {y3, y2, y1, y0};
    assign cnt_inc = cnt_q + CntOne;

    // Next-state logic for the debounce / handshake FSM.
    always_comb begin
        state_d  = state_q;
        snap_d   = snap_q;
        cnt_d    = cnt_q;
        load     = 1'b0;
        load_pat = snap_q;
        unique case (state_q)
            StIdle: begin
                if (req != 4'b0000) begin
                    snap_d = req;
                    cnt_d  = CntOne;
                    if (STABLE_CYCLES == 1) begin
                        state_d  = StValid;
                        load     = 1'b1;
                        load_pat = req;
                    end else begin
                        state_d = StStable;
                    end
                end
            end
            StStable: begin
                if (req == 4'b0000) begin
                    // Glitch: drop back without producing a result.
                    state_d = StIdle;
                    cnt_d   = '0;
                    snap_d  = 4'b0000;
                end else if (req == snap_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == StableCnt) begin
                        state_d  = StValid;
                        load     = 1'b1;
                        load_pat = snap_q;
                    end
                end else begin
                    snap_d = req;
                    cnt_d  = CntOne;
                end
            end
            StValid: begin
                if (ready) begin
                    state_d = StRelease;
                    cnt_d   = '0;
                end
            end
            StRelease: begin
                if (req == 4'b0000) begin
                    state_d = StIdle;
                    snap_d  = 4'b0000;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                snap_d  = 4'b0000;
            end
        endcase
    end

    // Result encoding; outputs only change when a new capture enters VALID.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        multi_d = multi_q;
        if (load) begin
            a_d     = load_pat[3] | load_pat[2];
            b_d     = load_pat[3] | (~load_pat[2] & load_pat[1]);
            multi_d = ({2'b00, load_pat[0]} + {2'b00, load_pat[1]} +
                       {2'b00, load_pat[2]} + {2'b00, load_pat[3]}) >= 3'd2;
        end
        valid_d = (state_d == StValid);
        busy_d  = (state_d != StIdle);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            snap_q  <= 4'b0000;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            multi_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            multi_q <= multi_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign a     = a_q;
    assign b     = b_q;
    assign multi = multi_q;
    assign valid = valid_q;
    assign busy  = busy_q;

endmodule
